// File: rtl/mem_seq_pkg.sv
// Shared encodings for the byte-serial memory sequencer: FSM states,
// transfer-size codes and the byte-count rule.
package mem_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [1:0] SZ1 = 2'd0;
    localparam logic [1:0] SZ2 = 2'd1;
    localparam logic [1:0] SZ4 = 2'd2;
    localparam logic [1:0] SZ8 = 2'd3;

    // Bytes moved for a size code, clamped to what the datapath can hold.
    function automatic int unsigned xfer_bytes(input logic [1:0] size, input int unsigned maxb);
        int unsigned n;
        case (size)
            SZ1:     n = 1;
            SZ2:     n = 2;
            SZ4:     n = 4;
            default: n = 8;
        endcase
        return (n > maxb) ? maxb : n;
    endfunction

endpackage

// File: rtl/mem_seq_byte_lane.sv
// Byte lane steering: picks the outgoing write byte and merges/extends
// incoming read bytes into the assembled read word.
module byte_lane #(
    parameter  int unsigned MAXB = 8,
    localparam int unsigned CW   = $clog2(MAXB) + 1
) (
    input  logic [8*MAXB-1:0] wdata,
    input  logic [CW-1:0]     wr_idx,
    output logic [7:0]        wr_byte,
    input  logic [8*MAXB-1:0] rdata_cur,
    input  logic [7:0]        rd_byte,
    input  logic [CW-1:0]     rd_idx,
    input  logic [CW-1:0]     nbytes,
    input  logic              sext,
    output logic [8*MAXB-1:0] rd_ins,
    output logic [8*MAXB-1:0] rd_ext
);

    logic [8*MAXB-1:0] wsh;
    logic              fill;

    assign wsh     = wdata >> {wr_idx, 3'b000};
    assign wr_byte = wsh[7:0];

    // Extension is taken from the word with the final byte already merged,
    // so the last capture and the fill land on the same edge.
    always_comb begin
        rd_ins = rdata_cur;
        for (int unsigned k = 0; k < MAXB; k++) begin
            if (k == 32'(rd_idx)) rd_ins[8*k +: 8] = rd_byte;
        end
        fill = 1'b0;
        for (int unsigned k = 0; k < MAXB; k++) begin
            if (k + 1 == 32'(nbytes)) fill = sext & rd_ins[8*k+7];
        end
        rd_ext = rd_ins;
        for (int unsigned k = 0; k < MAXB; k++) begin
            if (k >= 32'(nbytes)) rd_ext[8*k +: 8] = {8{fill}};
        end
    end

endmodule

// File: rtl/mem_seq.sv
// Byte-serial memory sequencer: splits 1/2/4/8-byte little-endian transfers
// into single-byte accesses to a RAM with one-cycle read latency.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int unsigned MAXB = 8,
    parameter int unsigned AW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [AW-1:0]     addr,
    input  logic [8*MAXB-1:0] wdata,
    output logic [8*MAXB-1:0] rdata,
    output logic              kp,
    output logic              done,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam int unsigned   CW  = $clog2(MAXB) + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic [CW-1:0]     nbytes;
    logic              sext_q;
    logic [AW-1:0]     addr_q;
    logic [8*MAXB-1:0] wdata_q;
    logic [8*MAXB-1:0] rd_ins;
    logic [8*MAXB-1:0] rd_ext;

    assign cnt_nx = cnt + ONE;

    byte_lane #(.MAXB(MAXB)) u_lane (
        .wdata     (wdata_q),
        .wr_idx    (cnt),
        .wr_byte   (ram_wdata),
        .rdata_cur (rdata),
        .rd_byte   (ram_rdata),
        .rd_idx    (cnt - ONE),
        .nbytes    (nbytes),
        .sext      (sext_q),
        .rd_ins    (rd_ins),
        .rd_ext    (rd_ext)
    );

    always_comb begin
        ram_addr = (state == ST_IDLE) ? addr : addr_q + AW'(cnt);
        ram_we   = (state == ST_WRITE);
        kp       = (state != ST_IDLE);
        done     = (state == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            nbytes  <= '0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        sext_q  <= sext;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        nbytes  <= CW'(xfer_bytes(size, MAXB));
                        cnt     <= '0;
                        state   <= we ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (cnt_nx == nbytes) begin
                        cnt   <= '0;
                        state <= ST_FIN;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                // Capture trails the address by one cycle; count N holds the last byte.
                ST_READ: begin
                    if (cnt == nbytes) begin
                        rdata <= rd_ext;
                        cnt   <= '0;
                        state <= ST_FIN;
                    end else begin
                        if (cnt != '0) rdata <= rd_ins;
                        cnt <= cnt_nx;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
// Randomised bench for mem_seq: MAXB=8 and MAXB=4 instances share stimulus,
// each against its own RAM and a transaction-level byte-array reference.
module tb_mem_seq;

    logic        clk = 1'b0;
    logic        rst_n, req, we, sext;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [63:0] wdata;

    logic [63:0] rdata8;
    logic        kp8, done8, ram_we8;
    logic [15:0] ram_addr8;
    logic [7:0]  ram_wdata8, ram_rdata8;

    logic [31:0] rdata4;
    logic        kp4, done4, ram_we4;
    logic [15:0] ram_addr4;
    logic [7:0]  ram_wdata4, ram_rdata4;

    logic [7:0]  mem  [2][65536];
    logic [7:0]  refm [2][65536];
    logic [63:0] last_rd [2];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    mem_seq #(.MAXB(8), .AW(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .rdata(rdata8), .kp(kp8), .done(done8),
        .ram_addr(ram_addr8), .ram_we(ram_we8), .ram_wdata(ram_wdata8), .ram_rdata(ram_rdata8)
    );

    mem_seq #(.MAXB(4), .AW(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata[31:0]), .rdata(rdata4), .kp(kp4), .done(done4),
        .ram_addr(ram_addr4), .ram_we(ram_we4), .ram_wdata(ram_wdata4), .ram_rdata(ram_rdata4)
    );

    // Synchronous RAMs: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (ram_we8) mem[0][ram_addr8] <= ram_wdata8;
        ram_rdata8 <= mem[0][ram_addr8];
    end

    always @(posedge clk) begin
        if (ram_we4) mem[1][ram_addr4] <= ram_wdata4;
        ram_rdata4 <= mem[1][ram_addr4];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned nb(input logic [1:0] sz, input int unsigned maxb);
        int unsigned n;
        n = 32'd1 << sz;
        return (n > maxb) ? maxb : n;
    endfunction

    function automatic logic [63:0] model_read(input int d, input logic [15:0] a,
                                               input int unsigned n, input bit sx);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < n; i++) v |= 64'(refm[d][16'(a + i)]) << (8 * i);
        if (sx && v[8*n-1]) v |= ~64'd0 << (8 * n);
        return (d == 1) ? (v & 64'hFFFF_FFFF) : v;
    endfunction

    function automatic logic [63:0] cur_rdata(input int d);
        return (d == 0) ? rdata8 : {32'd0, rdata4};
    endfunction

    task automatic poke(input logic [15:0] a, input logic [7:0] b);
        for (int d = 0; d < 2; d++) begin
            mem[d][a]  = b;
            refm[d][a] = b;
        end
    endtask

    task automatic xfer(input bit w, input logic [1:0] sz, input bit sx,
                        input logic [15:0] a, input logic [63:0] wd, input bit busy_poke);
        int          first [2];
        int          dcnt  [2];
        int          kcnt  [2];
        logic [63:0] rd_at [2];
        int unsigned n;
        for (int d = 0; d < 2; d++) begin
            first[d] = 0; dcnt[d] = 0; kcnt[d] = 0; rd_at[d] = '0;
        end
        @(negedge clk);
        we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (kp8) kcnt[0]++;
            if (kp4) kcnt[1]++;
            if (done8) begin dcnt[0]++; if (first[0] == 0) first[0] = cyc; rd_at[0] = rdata8; end
            if (done4) begin dcnt[1]++; if (first[1] == 0) first[1] = cyc; rd_at[1] = {32'd0, rdata4}; end
            req = busy_poke && (cyc == 3);
            if (busy_poke && cyc == 3) begin we = ~w; addr = ~a; end
        end
        for (int d = 0; d < 2; d++) begin
            n = nb(sz, (d == 0) ? 8 : 4);
            check($sformatf("done_cycle[%0d]", d), 64'(first[d]), 64'(w ? n + 1 : n + 2));
            check($sformatf("done_count[%0d]", d), 64'(dcnt[d]), 64'd1);
            check($sformatf("busy_cycles[%0d]", d), 64'(kcnt[d]), 64'(w ? n + 1 : n + 2));
            if (w) begin
                for (int unsigned i = 0; i < n; i++) refm[d][16'(a + i)] = wd[8*i +: 8];
                for (int j = -1; j <= 8; j++)
                    check($sformatf("mem[%0d]@%h", d, 16'(a + j)), 64'(mem[d][16'(a + j)]),
                          64'(refm[d][16'(a + j)]));
                check($sformatf("rdata_hold[%0d]", d), cur_rdata(d), last_rd[d]);
            end else begin
                last_rd[d] = model_read(d, a, n, sx);
                check($sformatf("rdata[%0d]", d), rd_at[d], last_rd[d]);
            end
        end
    endtask

    task automatic reset_mid_read();
        @(negedge clk);
        we = 1'b0; size = 2'd3; sext = 1'b1; addr = 16'h0200; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("busy_before_rst", 64'({kp8, kp4}), 64'b11);
        rst_n = 1'b0;
        #1;
        check("rst_kp", 64'({kp8, kp4}), 64'd0);
        check("rst_done", 64'({done8, done4}), 64'd0);
        check("rst_we", 64'({ram_we8, ram_we4}), 64'd0);
        check("rst_rdata8", rdata8, 64'd0);
        check("rst_rdata4", {32'd0, rdata4}, 64'd0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] ra;
        for (int a = 0; a < 65536; a++) begin
            b = 8'($urandom);
            poke(16'(a), b);
        end
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = '0; sext = 1'b0;
        addr = '0; wdata = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(negedge clk);
        check("reset_kp", 64'({kp8, kp4}), 64'd0);
        check("reset_done", 64'({done8, done4}), 64'd0);
        check("reset_rdata", rdata8 | {32'd0, rdata4}, 64'd0);
        addr = 16'h1234;
        #1;
        check("idle_ram_addr", 64'(ram_addr8), 64'h1234);
        @(negedge clk);
        rst_n = 1'b1;

        xfer(1'b1, 2'd3, 1'b0, 16'h0010, 64'h0807060504030201, 1'b0);
        check("w8_last_byte", 64'(mem[0][16'h0017]), 64'h08);

        poke(16'h0020, 8'h00); poke(16'h0021, 8'h00);
        poke(16'h0022, 8'h00); poke(16'h0023, 8'h80);
        xfer(1'b0, 2'd2, 1'b1, 16'h0020, 64'd0, 1'b0);
        check("r4_sext", rdata8, 64'hFFFF_FFFF_8000_0000);

        poke(16'h0030, 8'hF0);
        xfer(1'b0, 2'd0, 1'b0, 16'h0030, 64'd0, 1'b0);
        check("r1_zext", rdata8, 64'h0000_0000_0000_00F0);

        xfer(1'b1, 2'd2, 1'b0, 16'hFFFE, 64'h0000_0000_DDCC_BBAA, 1'b0);
        check("wrap_byte3", 64'(mem[0][16'h0001]), 64'hDD);

        xfer(1'b0, 2'd3, 1'b0, 16'h0100, 64'd0, 1'b1);
        reset_mid_read();
        xfer(1'b0, 2'd1, 1'b1, 16'h0300, 64'd0, 1'b0);

        repeat (40) begin
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                             : 16'($urandom);
            xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ra, {$urandom, $urandom}, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
